// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA demosaic output path: channel-mask bit
// positions and the pixel record carried from the CFA core to frame memory.
package cfa_pkg;

  localparam int GREEN_BIT  = 2;
  localparam int RED_BIT    = 1;
  localparam int BLUE_BIT   = 0;

  localparam int CFA_ADDR_W = 17;
  localparam int CFA_DATA_W = 12;

  typedef struct packed {
    logic [CFA_ADDR_W-1:0] addr;
    logic [CFA_DATA_W-1:0] green;
    logic [CFA_DATA_W-1:0] red;
    logic [CFA_DATA_W-1:0] blue;
    logic [2:0]            mask;
  } cfa_pixel_t;

endpackage

// File: rtl/cfa_sync_fifo.sv
// Single-clock pixel FIFO with show-ahead read data; pointers wrap modulo
// DEPTH, which must be a power of two.
module cfa_sync_fifo
  import cfa_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic       i_wrEn,
  input  cfa_pixel_t i_wrData,
  input  logic       i_rdEn,
  output cfa_pixel_t o_rdData,
  output logic       o_empty
);

  localparam int PW = $clog2(DEPTH);

  cfa_pixel_t    r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [PW:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_wrEn) r_wrPtr <= r_wrPtr + 1'b1;
      if (i_rdEn) r_rdPtr <= r_rdPtr + 1'b1;
      case ({i_wrEn, i_rdEn})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (i_wrEn && !i_clear) r_mem[r_wrPtr] <= i_wrData;
  end

  assign o_rdData = r_mem[r_rdPtr];
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/cfa_writeback.sv
// CFA pipeline output stage: buffers interpolated pixels and drains them to
// the three-plane frame memory, with stall, overflow and frame-done flags.
module cfa_writeback
  import cfa_pkg::*;
#(
  parameter int addressBitWidth = CFA_ADDR_W,
  parameter int dataBitWidth    = CFA_DATA_W,
  parameter int fifoDepth       = 8,
  parameter int almostFullLevel = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [addressBitWidth-1:0]    frameLength,
  input  logic                          inValid,
  input  logic [addressBitWidth-1:0]    inAddress,
  input  logic [dataBitWidth-1:0]       inGreen,
  input  logic [dataBitWidth-1:0]       inRed,
  input  logic [dataBitWidth-1:0]       inBlue,
  input  logic [2:0]                    inMask,
  input  logic                          memReady,
  output logic [addressBitWidth-1:0]    writeAddress,
  output logic [dataBitWidth-1:0]       greenWrite,
  output logic [dataBitWidth-1:0]       redWrite,
  output logic [dataBitWidth-1:0]       blueWrite,
  output logic [2:0]                    writeEnable,
  output logic                          stall,
  output logic [$clog2(fifoDepth):0]    level,
  output logic                          overflow,
  output logic                          frameDone
);

  localparam int LW = $clog2(fifoDepth) + 1;

  cfa_pixel_t                 r_out;
  logic [LW-1:0]              r_level;
  logic                       r_stall;
  logic                       r_overflow;
  logic                       r_frameDone;
  logic [addressBitWidth-1:0] r_pixelCount;
  logic [addressBitWidth-1:0] r_frameLength;

  cfa_pixel_t                 w_pixel;
  cfa_pixel_t                 w_head;
  logic                       w_fifoEmpty;
  logic                       w_accept;
  logic                       w_push;
  logic                       w_drop;
  logic                       w_pop;
  logic                       w_outFree;
  logic                       w_bypass;
  logic                       w_fifoWr;
  logic                       w_fifoRd;
  logic [LW-1:0]              w_levelNext;
  logic [addressBitWidth-1:0] w_countNext;
  logic                       w_frameEnd;

  assign w_pixel = '{addr: inAddress, green: inGreen, red: inRed,
                     blue: inBlue, mask: inMask};

  // A zero mask writes nothing, so it is filtered here rather than stored.
  assign w_accept  = inValid && (inMask != 3'b000) && !start;
  assign w_push    = w_accept && (r_level <  LW'(fifoDepth));
  assign w_drop    = w_accept && (r_level == LW'(fifoDepth));
  assign w_pop     = (r_out.mask != 3'b000) && memReady && !start;
  assign w_outFree = (r_out.mask == 3'b000) || w_pop;

  // With nothing queued ahead, a new pixel skips the FIFO for one-cycle latency.
  assign w_bypass  = w_push && w_fifoEmpty && w_outFree;
  assign w_fifoWr  = w_push && !w_bypass;
  assign w_fifoRd  = !w_fifoEmpty && w_outFree && !start;

  always_comb begin
    w_levelNext = r_level;
    if (w_push && !w_pop)      w_levelNext = r_level + 1'b1;
    else if (!w_push && w_pop) w_levelNext = r_level - 1'b1;
  end

  assign w_countNext = r_pixelCount + 1'b1;
  assign w_frameEnd  = w_pop && (r_frameLength != '0) &&
                       (w_countNext == r_frameLength);

  cfa_sync_fifo #(
    .DEPTH (fifoDepth)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .i_clear  (start),
    .i_wrEn   (w_fifoWr),
    .i_wrData (w_pixel),
    .i_rdEn   (w_fifoRd),
    .o_rdData (w_head),
    .o_empty  (w_fifoEmpty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out <= '0;
    end else if (start) begin
      r_out <= '0;
    end else if (w_fifoRd) begin
      r_out <= w_head;
    end else if (w_bypass) begin
      r_out <= w_pixel;
    end else if (w_pop) begin
      r_out.mask <= 3'b000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level    <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (start) begin
      r_level    <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_level <= w_levelNext;
      r_stall <= (r_level >= LW'(almostFullLevel));
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pixelCount  <= '0;
      r_frameLength <= '0;
      r_frameDone   <= 1'b0;
    end else if (start) begin
      r_pixelCount  <= '0;
      r_frameLength <= frameLength;
      r_frameDone   <= 1'b0;
    end else begin
      r_frameDone <= w_frameEnd;
      if (w_frameEnd)  r_pixelCount <= '0;
      else if (w_pop)  r_pixelCount <= w_countNext;
    end
  end

  assign writeAddress = r_out.addr;
  assign greenWrite   = r_out.green;
  assign redWrite     = r_out.red;
  assign blueWrite    = r_out.blue;
  assign writeEnable  = r_out.mask;
  assign level        = r_level;
  assign stall        = r_stall;
  assign overflow     = r_overflow;
  assign frameDone    = r_frameDone;

endmodule

// File: tb/tb_cfa_writeback.sv
// Scoreboard bench for cfa_writeback: accepted pixels are queued when driven
// and compared in order as memory transfers occur.
module tb_cfa_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] frameLength;
  logic        inValid;
  logic [16:0] inAddress;
  logic [11:0] inGreen, inRed, inBlue;
  logic [2:0]  inMask;
  logic        memReady;
  logic [16:0] writeAddress;
  logic [11:0] greenWrite, redWrite, blueWrite;
  logic [2:0]  writeEnable;
  logic        stall;
  logic [3:0]  level;
  logic        overflow;
  logic        frameDone;

  typedef struct {
    logic [16:0] addr;
    logic [11:0] g, r, b;
    logic [2:0]  m;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   xfers = 0;
  int   doneCount = 0;
  int   mdlCount = 0;
  int   mdlLen = 0;
  bit   pendDone = 0;

  cfa_writeback dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .frameLength  (frameLength),
    .inValid      (inValid),
    .inAddress    (inAddress),
    .inGreen      (inGreen),
    .inRed        (inRed),
    .inBlue       (inBlue),
    .inMask       (inMask),
    .memReady     (memReady),
    .writeAddress (writeAddress),
    .greenWrite   (greenWrite),
    .redWrite     (redWrite),
    .blueWrite    (blueWrite),
    .writeEnable  (writeEnable),
    .stall        (stall),
    .level        (level),
    .overflow     (overflow),
    .frameDone    (frameDone)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Transfer monitor and frame-count model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("frameDone_in_reset", {31'd0, frameDone}, 32'd0);
      mdlCount = 0;
      mdlLen   = 0;
      pendDone = 0;
    end else begin
      check_eq("frameDone", {31'd0, frameDone}, {31'd0, pendDone});
      pendDone = 0;
      if (frameDone) doneCount++;
      if (start) begin
        mdlCount = 0;
        mdlLen   = int'(frameLength);
      end else if (writeEnable != 3'b000 && memReady) begin
        if (sb.size() == 0) begin
          check_eq("sb_unexpected_write", {29'd0, writeEnable}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("wr_addr",  {15'd0, writeAddress}, {15'd0, e.addr});
          check_eq("wr_green", {20'd0, greenWrite},   {20'd0, e.g});
          check_eq("wr_red",   {20'd0, redWrite},     {20'd0, e.r});
          check_eq("wr_blue",  {20'd0, blueWrite},    {20'd0, e.b});
          check_eq("wr_en",    {29'd0, writeEnable},  {29'd0, e.m});
        end
        xfers++;
        mdlCount++;
        if (mdlLen != 0 && mdlCount == mdlLen) begin
          pendDone = 1;
          mdlCount = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_px(input logic [16:0] a, input logic [11:0] g,
                          input logic [11:0] r, input logic [11:0] b,
                          input logic [2:0] m, input bit acc);
    exp_t e;
    e.addr = a; e.g = g; e.r = r; e.b = b; e.m = m;
    inValid = 1'b1; inAddress = a; inGreen = g; inRed = r; inBlue = b;
    inMask = m;
    if (acc) sb.push_back(e);
    tick();
    inValid = 1'b0;
  endtask

  task automatic drive_rand(input bit acc);
    drive_px(17'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
             3'($urandom_range(1, 7)), acc);
  endtask

  task automatic do_start(input logic [16:0] fl);
    start = 1'b1;
    frameLength = fl;
    sb.delete();
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_we"},   {29'd0, writeEnable},  32'd0);
    check_eq({pfx, "_addr"}, {15'd0, writeAddress}, 32'd0);
    check_eq({pfx, "_g"},    {20'd0, greenWrite},   32'd0);
    check_eq({pfx, "_r"},    {20'd0, redWrite},     32'd0);
    check_eq({pfx, "_b"},    {20'd0, blueWrite},    32'd0);
    check_eq({pfx, "_lvl"},  {28'd0, level},        32'd0);
    check_eq({pfx, "_stall"}, {31'd0, stall},       32'd0);
    check_eq({pfx, "_ovf"},  {31'd0, overflow},     32'd0);
    check_eq({pfx, "_done"}, {31'd0, frameDone},    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, d0, k;
    rst = 1'b0; start = 1'b0; frameLength = '0; inValid = 1'b0;
    inAddress = '0; inGreen = '0; inRed = '0; inBlue = '0; inMask = '0;
    memReady = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Single pixel
    do_start(17'd4);
    memReady = 1'b1;
    drive_px(17'h00010, 12'h123, 12'h000, 12'h000, 3'b100, 1'b1);
    check_eq("single_we",   {29'd0, writeEnable},  32'h4);
    check_eq("single_addr", {15'd0, writeAddress}, 32'h10);
    check_eq("single_g",    {20'd0, greenWrite},   32'h123);
    check_eq("single_lvl1", {28'd0, level},        32'd1);
    tick();
    check_eq("single_we0",  {29'd0, writeEnable},  32'd0);
    check_eq("single_lvl0", {28'd0, level},        32'd0);

    // Backpressure and stall timing
    memReady = 1'b0;
    drive_px(17'h00100, 12'hAAA, 12'hBBB, 12'hCCC, 3'b111, 1'b1);
    for (int i = 2; i <= 6; i++) drive_rand(1'b1);
    check_eq("bp_lvl6",   {28'd0, level}, 32'd6);
    check_eq("bp_stall0", {31'd0, stall}, 32'd0);
    tick();
    check_eq("bp_stall1", {31'd0, stall}, 32'd1);
    check_eq("bp_hold_addr", {15'd0, writeAddress}, 32'h100);
    check_eq("bp_hold_g",    {20'd0, greenWrite},   32'hAAA);
    check_eq("bp_hold_we",   {29'd0, writeEnable},  32'h7);
    x0 = xfers;
    memReady = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_eq("bp_nogap", xfers - x0, 32'd6);
    check_eq("bp_drained", {28'd0, level}, 32'd0);

    // Overflow
    do_start(17'd4);
    memReady = 1'b0;
    for (int i = 1; i <= 8; i++) drive_rand(1'b1);
    check_eq("ovf_lvl8",  {28'd0, level},    32'd8);
    check_eq("ovf_pre",   {31'd0, overflow}, 32'd0);
    drive_rand(1'b0);
    drive_rand(1'b0);
    check_eq("ovf_lvl8b", {28'd0, level},    32'd8);
    check_eq("ovf_set",   {31'd0, overflow}, 32'd1);
    memReady = 1'b1;
    drive_rand(1'b0);
    check_eq("ovf_pushpop_lvl", {28'd0, level}, 32'd7);
    k = 0;
    while (level != 4'd0 && k < 20) begin tick(); k++; end
    check_eq("ovf_drain_bound", {31'd0, (k >= 20)}, 32'd0);
    check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);
    check_eq("ovf_sb_empty", sb.size(), 32'd0);
    do_start(17'd4);
    check_eq("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Frame count at full rate
    d0 = doneCount;
    for (int i = 0; i < 4; i++) drive_rand(1'b1);
    tick(); tick(); tick();
    check_eq("frame_one_pulse", doneCount - d0, 32'd1);
    drive_rand(1'b1);
    tick(); tick(); tick();
    check_eq("frame_no_extra", doneCount - d0, 32'd1);

    // frameLength = 0 never completes
    do_start(17'd0);
    d0 = doneCount;
    for (int i = 0; i < 5; i++) drive_rand(1'b1);
    tick(); tick(); tick();
    check_eq("frame_len0", doneCount - d0, 32'd0);

    // Mask filter and start priority
    do_start(17'd4);
    memReady = 1'b0;
    drive_px(17'h1F0F0, 12'h111, 12'h222, 12'h333, 3'b000, 1'b0);
    check_eq("mask0_lvl", {28'd0, level},       32'd0);
    check_eq("mask0_we",  {29'd0, writeEnable}, 32'd0);
    check_eq("mask0_ovf", {31'd0, overflow},    32'd0);
    for (int i = 0; i < 3; i++) drive_rand(1'b1);
    check_eq("start_pre_lvl", {28'd0, level}, 32'd3);
    inValid = 1'b1; inMask = 3'b111;
    do_start(17'd4);
    inValid = 1'b0;
    check_eq("start_lvl", {28'd0, level},       32'd0);
    check_eq("start_ovf", {31'd0, overflow},    32'd0);
    check_eq("start_we",  {29'd0, writeEnable}, 32'd0);

    // Asynchronous reset with a pending write
    drive_rand(1'b1);
    drive_rand(1'b1);
    check_eq("arst_pending", {31'd0, (writeEnable != 3'b000)}, 32'd1);
    #2;
    rst = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("arst");
    tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
